timer_counter_core: RTL and testbench



---
 rtl/timer_counter_core.sv | 140 ++++++++++++++
 tb/tb_timer_counter_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_core.sv
// Timer counter core: a WIDTH-bit up/down counter advanced by the rising edges
// of a selectable tick source. It supports explicit load, free-run or reload
// wrap, one-shot stop, and sticky overflow/underflow flags.
module timer_counter_core #(
    parameter int WIDTH   = 8,
    parameter int NUM_CLK = 4,
    parameter int SEL_W   = 2
) (
    input  logic               PCLK,
    input  logic               RST,
    input  logic [NUM_CLK-1:0] clk_in,
    input  logic [SEL_W-1:0]   clk_sel,
    input  logic [WIDTH-1:0]   tdr,
    input  logic               load,
    input  logic               en,
    input  logic               dir,
    input  logic               reload_mode,
    input  logic               one_shot,
    input  logic               ovf_clr,
    input  logic               udf_clr,
    output logic [WIDTH-1:0]   cnt,
    output logic               ovf,
    output logic               udf,
    output logic               wrap_pulse,
    output logic               running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             sel_tick;
    logic             tick_q;
    logic             tick;
    logic             count_en;
    logic             ovf_evt;
    logic             udf_evt;
    logic [WIDTH-1:0] cnt_next;

    // Select the tick source; an out-of-range select yields a constant-low source.
    always_comb begin
        sel_tick = 1'b0;
        for (int i = 0; i < NUM_CLK; i++) begin
            if (clk_sel == SEL_W'(i)) begin
                sel_tick = clk_in[i];
            end
        end
    end

    // Remember the previous selected-source level for rising-edge detection.
    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= sel_tick;
        end
    end

    assign tick = sel_tick & ~tick_q;

    assign count_en = (state == RUN) && en && tick && !load;
    assign ovf_evt  = count_en && !dir && (cnt == {WIDTH{1'b1}});
    assign udf_evt  = count_en &&  dir && (cnt == {WIDTH{1'b0}});

    // Work out the next count: load wins, then wrap values, then a plain step.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = tdr;
        end else if (ovf_evt) begin
            cnt_next = reload_mode ? tdr : {WIDTH{1'b0}};
        end else if (udf_evt) begin
            cnt_next = reload_mode ? tdr : {WIDTH{1'b1}};
        end else if (count_en) begin
            cnt_next = dir ? (cnt - WIDTH'(1)) : (cnt + WIDTH'(1));
        end
    end

    // Count, flag and wrap-pulse registers; a set event beats a same-cycle clear.
    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            cnt        <= '0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            ovf        <= ovf_evt | (ovf & ~ovf_clr);
            udf        <= udf_evt | (udf & ~udf_clr);
            wrap_pulse <= ovf_evt | udf_evt;
        end
    end

    // State register.
    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a one-shot wrap parks in DONE until the next load.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (en) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if ((ovf_evt || udf_evt) && one_shot) begin
                    next_state = DONE;
                end else if (!en) begin
                    next_state = IDLE;
                end
            end
            DONE: begin
                if (load) begin
                    next_state = en ? RUN : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        running = 1'b0;
        if (state == RUN) begin
            running = 1'b1;
        end
    end

endmodule

// File: tb/tb_timer_counter_core.sv
// Directed bench for timer_counter_core (WIDTH=8, NUM_CLK=3) with
// hand-computed expected values checked by immediate assertions.
module tb_timer_counter_core;

    localparam int WIDTH   = 8;
    localparam int NUM_CLK = 3;
    localparam int SEL_W   = 2;

    logic               PCLK;
    logic               RST;
    logic [NUM_CLK-1:0] clk_in;
    logic [SEL_W-1:0]   clk_sel;
    logic [WIDTH-1:0]   tdr;
    logic               load;
    logic               en;
    logic               dir;
    logic               reload_mode;
    logic               one_shot;
    logic               ovf_clr;
    logic               udf_clr;
    logic [WIDTH-1:0]   cnt;
    logic               ovf;
    logic               udf;
    logic               wrap_pulse;
    logic               running;

    int checks = 0;
    int errors = 0;
    int wrap_seen;

    timer_counter_core #(
        .WIDTH  (WIDTH),
        .NUM_CLK(NUM_CLK),
        .SEL_W  (SEL_W)
    ) dut (
        .PCLK       (PCLK),
        .RST        (RST),
        .clk_in     (clk_in),
        .clk_sel    (clk_sel),
        .tdr        (tdr),
        .load       (load),
        .en         (en),
        .dir        (dir),
        .reload_mode(reload_mode),
        .one_shot   (one_shot),
        .ovf_clr    (ovf_clr),
        .udf_clr    (udf_clr),
        .cnt        (cnt),
        .ovf        (ovf),
        .udf        (udf),
        .wrap_pulse (wrap_pulse),
        .running    (running)
    );

    // Free-running system clock.
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Advance one PCLK cycle and settle just after the rising edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // One full pulse on the given clk_in bits: high for one cycle, then low.
    task automatic applyStimulus(input logic [NUM_CLK-1:0] mask);
        clk_in = mask;
        step();
        clk_in = '0;
        step();
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, up/down counting, one-shot, flags, load and reset.
    initial begin
        RST         = 1'b0;
        clk_in      = '0;
        clk_sel     = '0;
        tdr         = '0;
        load        = 1'b0;
        en          = 1'b0;
        dir         = 1'b0;
        reload_mode = 1'b0;
        one_shot    = 1'b0;
        ovf_clr     = 1'b0;
        udf_clr     = 1'b0;

        // Reset state
        #12;
        checkOutput("reset_cnt", 32'(cnt), 32'h00);
        checkOutput("reset_ovf", 32'(ovf), 32'h0);
        checkOutput("reset_udf", 32'(udf), 32'h0);
        checkOutput("reset_wrap", 32'(wrap_pulse), 32'h0);
        checkOutput("reset_running", 32'(running), 32'h0);

        // 256 up ticks from zero: single overflow at 0xFF -> 0x00
        step();
        RST = 1'b1;
        en  = 1'b1;
        step();
        step();
        checkOutput("run_after_en", 32'(running), 32'h1);
        wrap_seen = 0;
        for (int i = 0; i < 255; i++) begin
            clk_in = 3'b001;
            step();
            if (wrap_pulse) wrap_seen++;
            clk_in = '0;
            step();
            if (wrap_pulse) wrap_seen++;
        end
        checkOutput("up255_cnt", 32'(cnt), 32'hFF);
        checkOutput("up255_ovf", 32'(ovf), 32'h0);
        checkOutput("up255_no_wrap", 32'(wrap_seen), 32'h0);
        clk_in = 3'b001;
        step();
        checkOutput("up256_cnt", 32'(cnt), 32'h00);
        checkOutput("up256_ovf", 32'(ovf), 32'h1);
        checkOutput("up256_wrap_hi", 32'(wrap_pulse), 32'h1);
        clk_in = '0;
        step();
        checkOutput("up256_wrap_lo", 32'(wrap_pulse), 32'h0);

        // Down count with reload from tdr = 0x03
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", 32'(ovf), 32'h0);
        tdr         = 8'h03;
        dir         = 1'b1;
        reload_mode = 1'b1;
        load        = 1'b1;
        step();
        load = 1'b0;
        checkOutput("load_03", 32'(cnt), 32'h03);
        clk_in = 3'b001;
        #2;
        checkOutput("latency_before_edge", 32'(cnt), 32'h03);
        step();
        checkOutput("down_tick1", 32'(cnt), 32'h02);
        clk_in = '0;
        step();
        applyStimulus(3'b001);
        checkOutput("down_tick2", 32'(cnt), 32'h01);
        applyStimulus(3'b001);
        checkOutput("down_tick3", 32'(cnt), 32'h00);
        checkOutput("down_no_udf_yet", 32'(udf), 32'h0);
        applyStimulus(3'b001);
        checkOutput("down_reload", 32'(cnt), 32'h03);
        checkOutput("down_udf", 32'(udf), 32'h1);

        // One-shot from 0xFE counting up with free-run wrap
        udf_clr = 1'b1;
        step();
        udf_clr = 1'b0;
        checkOutput("udf_cleared", 32'(udf), 32'h0);
        dir         = 1'b0;
        reload_mode = 1'b0;
        one_shot    = 1'b1;
        tdr         = 8'hFE;
        load        = 1'b1;
        step();
        load = 1'b0;
        applyStimulus(3'b001);
        checkOutput("os_tick1", 32'(cnt), 32'hFF);
        checkOutput("os_tick1_running", 32'(running), 32'h1);
        applyStimulus(3'b001);
        checkOutput("os_tick2_cnt", 32'(cnt), 32'h00);
        checkOutput("os_tick2_running", 32'(running), 32'h0);
        applyStimulus(3'b001);
        checkOutput("os_tick3_cnt", 32'(cnt), 32'h00);
        checkOutput("os_tick3_running", 32'(running), 32'h0);
        tdr  = 8'h10;
        load = 1'b1;
        step();
        load = 1'b0;
        checkOutput("os_reload_cnt", 32'(cnt), 32'h10);
        checkOutput("os_reload_running", 32'(running), 32'h1);
        applyStimulus(3'b001);
        checkOutput("os_resume", 32'(cnt), 32'h11);
        one_shot = 1'b0;

        // Set beats clear on the same cycle; a lone clear then drops the flag
        checkOutput("ovf_still_set", 32'(ovf), 32'h1);
        tdr  = 8'hFF;
        load = 1'b1;
        step();
        load    = 1'b0;
        clk_in  = 3'b001;
        ovf_clr = 1'b1;
        step();
        checkOutput("set_over_clr_ovf", 32'(ovf), 32'h1);
        checkOutput("set_over_clr_cnt", 32'(cnt), 32'h00);
        clk_in  = '0;
        ovf_clr = 1'b0;
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checkOutput("clr_alone_ovf", 32'(ovf), 32'h0);

        // Load and tick in the same cycle: load wins, tick discarded
        tdr    = 8'h40;
        load   = 1'b1;
        clk_in = 3'b001;
        step();
        checkOutput("load_tick_cnt", 32'(cnt), 32'h40);
        checkOutput("load_tick_wrap", 32'(wrap_pulse), 32'h0);
        load   = 1'b0;
        clk_in = '0;
        step();
        checkOutput("load_tick_hold", 32'(cnt), 32'h40);

        // Out-of-range select produces no ticks; a valid high index does
        clk_sel = 2'd3;
        step();
        applyStimulus(3'b111);
        applyStimulus(3'b111);
        checkOutput("sel3_hold", 32'(cnt), 32'h40);
        clk_sel = 2'd2;
        step();
        applyStimulus(3'b100);
        checkOutput("sel2_tick", 32'(cnt), 32'h41);
        clk_sel = 2'd0;
        step();

        // Asynchronous reset mid-count at 0x55
        tdr  = 8'hFF;
        load = 1'b1;
        step();
        load = 1'b0;
        applyStimulus(3'b001);
        tdr  = 8'h54;
        load = 1'b1;
        step();
        load = 1'b0;
        applyStimulus(3'b001);
        checkOutput("pre_reset_cnt", 32'(cnt), 32'h55);
        checkOutput("pre_reset_ovf", 32'(ovf), 32'h1);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("async_reset_cnt", 32'(cnt), 32'h00);
        checkOutput("async_reset_ovf", 32'(ovf), 32'h0);
        checkOutput("async_reset_udf", 32'(udf), 32'h0);
        checkOutput("async_reset_running", 32'(running), 32'h0);
        en = 1'b0;
        step();
        RST = 1'b1;
        step();
        applyStimulus(3'b001);
        checkOutput("post_reset_no_en_cnt", 32'(cnt), 32'h00);
        checkOutput("post_reset_no_en_running", 32'(running), 32'h0);
        en = 1'b1;
        step();
        checkOutput("post_reset_en_running", 32'(running), 32'h1);
        applyStimulus(3'b001);
        checkOutput("post_reset_count", 32'(cnt), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
